// File: rtl/regfile_alu_seq.sv
// Command sequencer plus 8-bit ALU for register8x16: fetches two operands,
// computes one result and writes it back through the single write port.
module regfile_alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_rd,
  input  logic [3:0] cmd_rs1,
  input  logic [3:0] cmd_rs2,
  input  logic [7:0] cmd_imm,
  output logic [3:0] raddr1,
  output logic [3:0] raddr2,
  input  logic [7:0] rdata1,
  input  logic [7:0] rdata2,
  output logic       we,
  output logic [3:0] waddr,
  output logic [7:0] wdata,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       done
);

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_SHL = 3'd5;
  localparam logic [OPW-1:0] OP_SHR = 3'd6;
  localparam logic [OPW-1:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e          state_q;
  logic            read_wait_q;
  logic [OPW-1:0]  op_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   imm_q;
  logic [DW-1:0]   opa_q;
  logic [DW-1:0]   opb_q;

  logic [DW-1:0]   alu_res_d;
  logic            alu_c_d;

  // ALU datapath; carry/borrow comes from bit 8 of a 9-bit intermediate
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    unique case (op_q)
      OP_ADD: {alu_c_d, alu_res_d} = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB: {alu_c_d, alu_res_d} = {1'b0, opa_q} - {1'b0, opb_q};
      OP_AND: alu_res_d = opa_q & opb_q;
      OP_OR:  alu_res_d = opa_q | opb_q;
      OP_XOR: alu_res_d = opa_q ^ opb_q;
      OP_SHL: begin
        alu_res_d = {opa_q[DW-2:0], 1'b0};
        alu_c_d   = opa_q[DW-1];
      end
      OP_SHR: begin
        alu_res_d = {1'b0, opa_q[DW-1:1]};
        alu_c_d   = opa_q[0];
      end
      OP_LDI: alu_res_d = imm_q;
    endcase
  end

  // Sequencer; READ spans two cycles so the register-file read path gets a
  // full cycle after the address registers update before operands are latched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      read_wait_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_ready   <= 1'b1;
      raddr1      <= '0;
      raddr2      <= '0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      result      <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      done        <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            imm_q       <= cmd_imm;
            raddr1      <= cmd_rs1;
            raddr2      <= cmd_rs2;
            cmd_ready   <= 1'b0;
            read_wait_q <= 1'b1;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (read_wait_q) begin
            read_wait_q <= 1'b0;
          end else begin
            opa_q   <= rdata1;
            opb_q   <= rdata2;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result  <= alu_res_d;
          flag_c  <= alu_c_d;
          flag_z  <= (alu_res_d == '0);
          wdata   <= alu_res_d;
          waddr   <= rd_q;
          we      <= 1'b1;
          done    <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          cmd_ready <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
